fx2_ep6_packetizer: RTL
=======================

// Module: fx2_ep6_packetizer
// PURPOSE
//  Parametrised successor to the fixed I/Q EP6 writer. Takes NUM_CH-channel
//  sample frames from an upstream FIFO (valid/ready) and emits framed packets
//  into the FX2 slave FIFO, one 16-bit word per IFCLK max.
//  Packet = SYNC word, 16-bit sequence number, then FRAMES_PER_PKT frames of
//  NUM_CH words (ch0..chN-1). Defaults give 256 words = one 512-byte EP6 buffer.
// PARAMETERS
//  NUM_CH          2        channels (words) per frame, 1..8
//  DATA_W          16       sample width, 8..16; sign-extended to 16 on FD
//  FRAMES_PER_PKT  127      frames per packet, >=1
//  SYNC            16'h7F7F first word of every packet
// PORTS
//  IFCLK         in   1             FX2 interface clock; only clock
//  reset_n       in   1             asynchronous, active-low reset
//  enable        in   1             1 = start new packets; sampled in IDLE only
//  in_data       in   NUM_CH*DATA_W frame; ch k = bits [k*DATA_W +: DATA_W]
//  in_valid      in   1             frame available upstream
//  in_ready      out  1             frame consumed this cycle when in_valid=1
//  FLAGB         in   1             EP6 full flag, active low (0 = full)
//  FD            out  16            FX2 FIFO data
//  SLWR          out  1             FX2 write strobe, active low
//  SLRD          out  1             constant 1 (never read)
//  SLOE          out  1             constant 1
//  FIFO_ADR      out  2             constant 2'b10 (EP6)
//  seq           out  16            sequence number of next packet
//  pkt_done      out  1             1-cycle pulse after last word of a packet
// BEHAVIOUR
//  Reset: FD=0, SLWR=1, in_ready=0, seq=0, pkt_done=0, state=IDLE, counters 0.
//  FD/SLWR registered: a word decided in cycle n is on FD with SLWR=0 in n+1.
//  Any cycle with no write: SLWR<=1, FD holds. nf = FLAGB (1 = not full).
//  States:
//   IDLE    : enable=1 -> HDR_SYNC; else stay.
//   HDR_SYNC: nf -> FD<=SYNC, SLWR<=0, ->HDR_SEQ; else stall.
//   HDR_SEQ : nf -> FD<=seq, SLWR<=0, ->PAYLOAD, ch=0, frm=0; else stall.
//   PAYLOAD ch==0: in_ready = nf (combinational). Fire = in_valid & in_ready:
//     latch whole frame into shadow reg, FD<=ext(ch0), SLWR<=0, ch<=1.
//     No fire -> SLWR<=1, stay.
//   PAYLOAD ch>0: in_ready=0; nf -> FD<=ext(shadow[ch]), SLWR<=0, ch++;
//     else stall, shadow held.
//   Last word of frame (ch==NUM_CH-1, or ch0 fire when NUM_CH=1): ch<=0, frm++.
//   Last word of last frame: seq<=seq+1 (wraps FFFF->0000), pkt_done<=1,
//     ->HDR_SYNC if enable=1 else IDLE.
//  ext(): sign-extend DATA_W to 16; DATA_W=16 passes unchanged.
//  enable=0 mid-packet: packet always completes; no short packets ever.
//  Full mid-frame: stall only; word order and content unchanged; no drops.
//  in_valid=0 in PAYLOAD: wait indefinitely; header is never repeated.
//  in_ready never asserted outside PAYLOAD ch==0; upstream never overrun.
//  reset_n low mid-packet: immediate return to reset values; partial packet
//   abandoned, seq restarts at 0.
//  Throughput: 1 word/cycle when nf=1 and in_valid=1 continuously;
//   packet = 2 + NUM_CH*FRAMES_PER_PKT cycles, back-to-back with enable=1.
// TESTING
//  1 Defaults, FLAGB=1, in_valid=1, ch0=16'h1234, ch1=16'hABCD, enable=1 ->
//    256 consecutive SLWR=0 words: 7F7F,0000,1234,ABCD..., pkt_done, next 0001.
//  2 NUM_CH=4, DATA_W=12, ch0=12'h800, ch1=12'h7FF -> FD F800, 07FF; 4 words
//    per frame, packet length 2+4*127 = 510 words.
//  3 FLAGB=0 for 5 cycles mid-frame (after ch0 word) -> SLWR=1 those cycles,
//    in_ready=0, next word is ch1 of same frame, no duplicate/missing words.
//  4 Drop enable during frame 10 of packet -> packet completes all 127 frames,
//    state IDLE, SLWR=1, in_ready=0 thereafter; re-enable -> SYNC, seq+1.
//  5 Preload seq to FFFF (run 65535 packets, FRAMES_PER_PKT=1) -> header seq
//    FFFF, then 0000 on next packet.
//  6 reset_n low 1 cycle mid-payload -> FD=0, SLWR=1, seq=0 asynchronously;
//    after release + enable, packet restarts with 7F7F,0000.

Source files
------------

// File: rtl/fx2_ep6_packetizer_if.sv
// rtl/fx2_ep6_packetizer_if.sv - upstream frame stream plus FX2 slave-FIFO bus for the EP6 packetizer
interface fx2_ep6_packetizer_if #(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 16
);
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic                     in_valid;
  logic                     in_ready;
  logic                     FLAGB;
  logic [15:0]              FD;
  logic                     SLWR;
  logic                     SLRD;
  logic                     SLOE;
  logic [1:0]               FIFO_ADR;

  modport master (
    input  in_data, in_valid, FLAGB,
    output in_ready, FD, SLWR, SLRD, SLOE, FIFO_ADR
  );

  modport slave (
    output in_data, in_valid, FLAGB,
    input  in_ready, FD, SLWR, SLRD, SLOE, FIFO_ADR
  );
endinterface

// File: rtl/fx2_ep6_packetizer.sv
// rtl/fx2_ep6_packetizer.sv - frames NUM_CH-channel samples into SYNC/seq/payload packets for FX2 EP6
module fx2_ep6_packetizer #(
  parameter int          NUM_CH         = 2,
  parameter int          DATA_W         = 16,
  parameter int          FRAMES_PER_PKT = 127,
  parameter logic [15:0] SYNC           = 16'h7F7F
) (
  input  logic                IFCLK,
  input  logic                reset_n,
  input  logic                enable,
  fx2_ep6_packetizer_if.master bus,
  output logic [15:0]         seq,
  output logic                pkt_done
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int FRM_W = (FRAMES_PER_PKT > 1) ? $clog2(FRAMES_PER_PKT) : 1;
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);
  localparam logic [FRM_W-1:0] LAST_FRM = FRM_W'(FRAMES_PER_PKT - 1);

  typedef enum logic [1:0] {IDLE, HDR_SYNC, HDR_SEQ, PAYLOAD} state_t;

  state_t                   state_q, state_d;
  logic [CH_W-1:0]          ch_q, ch_d;
  logic [FRM_W-1:0]         frm_q, frm_d;
  logic [NUM_CH*DATA_W-1:0] shadow_q, shadow_d;
  logic [15:0]              fd_q, fd_d;
  logic [15:0]              seq_q, seq_d;
  logic                     slwr_q, slwr_d;
  logic                     pkt_done_q, pkt_done_d;
  logic                     nf;
  logic                     word_wr;
  logic                     in_ready;
  logic [15:0]              shadow_ext [NUM_CH];
  logic [15:0]              in_ext0;

  function automatic logic [15:0] ext(input logic [DATA_W-1:0] v);
    return 16'($signed(v));
  endfunction

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      shadow_ext[k] = ext(shadow_q[k*DATA_W +: DATA_W]);
    end
    in_ext0 = ext(bus.in_data[DATA_W-1:0]);
  end

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    frm_d      = frm_q;
    shadow_d   = shadow_q;
    fd_d       = fd_q;
    seq_d      = seq_q;
    slwr_d     = 1'b1;
    pkt_done_d = 1'b0;
    in_ready   = 1'b0;
    word_wr    = 1'b0;
    nf         = bus.FLAGB;
    case (state_q)
      IDLE: begin
        if (enable) state_d = HDR_SYNC;
      end
      HDR_SYNC: begin
        if (nf) begin
          fd_d    = SYNC;
          slwr_d  = 1'b0;
          state_d = HDR_SEQ;
        end
      end
      HDR_SEQ: begin
        if (nf) begin
          fd_d    = seq_q;
          slwr_d  = 1'b0;
          ch_d    = '0;
          frm_d   = '0;
          state_d = PAYLOAD;
        end
      end
      PAYLOAD: begin
        // Only ch0 pulls from upstream; later channels replay the latched frame.
        if (ch_q == '0) begin
          in_ready = nf;
          if (bus.in_valid && nf) begin
            shadow_d = bus.in_data;
            fd_d     = in_ext0;
            word_wr  = 1'b1;
          end
        end else if (nf) begin
          fd_d    = shadow_ext[ch_q];
          word_wr = 1'b1;
        end
        if (word_wr) begin
          slwr_d = 1'b0;
          if (ch_q == LAST_CH) begin
            ch_d = '0;
            if (frm_q == LAST_FRM) begin
              frm_d      = '0;
              seq_d      = seq_q + 16'd1;
              pkt_done_d = 1'b1;
              state_d    = enable ? HDR_SYNC : IDLE;
            end else begin
              frm_d = frm_q + 1'b1;
            end
          end else begin
            ch_d = ch_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge IFCLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      ch_q       <= '0;
      frm_q      <= '0;
      shadow_q   <= '0;
      fd_q       <= '0;
      seq_q      <= '0;
      slwr_q     <= 1'b1;
      pkt_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      frm_q      <= frm_d;
      shadow_q   <= shadow_d;
      fd_q       <= fd_d;
      seq_q      <= seq_d;
      slwr_q     <= slwr_d;
      pkt_done_q <= pkt_done_d;
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.FD       = fd_q;
  assign bus.SLWR     = slwr_q;
  assign bus.SLRD     = 1'b1;
  assign bus.SLOE     = 1'b1;
  assign bus.FIFO_ADR = 2'b10;
  assign seq          = seq_q;
  assign pkt_done     = pkt_done_q;
endmodule
